// File: rtl/sevseg_scan_ctrl.sv
// N-digit seven-segment scan multiplexer: frame-coherent shadows, per-digit enable, DP,
// inter-digit blanking and PWM brightness. Optional raw segment override: SEVSEG_RAW_EN.
module sevseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int BRIGHT_W   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_DIGITS*4-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_en,
  input  logic [BRIGHT_W-1:0]     i_bright,
`ifdef SEVSEG_RAW_EN
  input  logic [NUM_DIGITS*8-1:0] i_raw,
  input  logic [NUM_DIGITS-1:0]   i_raw_sel,
`endif
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_FIRST = SLOT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic              POL         = ACTIVE_LOW;

  logic                    r_started;
  logic [SLOT_W-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BRIGHT_W-1:0]     r_bright_cnt;
  logic [NUM_DIGITS*4-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic [BRIGHT_W-1:0]     r_sh_bright;
`ifdef SEVSEG_RAW_EN
  logic [NUM_DIGITS*8-1:0] r_sh_raw;
  logic [NUM_DIGITS-1:0]   r_sh_raw_sel;
  logic [7:0]              w_raw_byte;
`endif
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame;

  logic                    w_slot_wrap;
  logic                    w_load;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [3:0]              w_nib;
  logic [6:0]              w_hex;
  logic [6:0]              w_seg;
  logic                    w_dp;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an;

  // The first clock after reset loads the shadows so the display never shows reset zeros for a frame.
  always_comb begin
    w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    w_load      = !r_started || (w_slot_wrap && (r_idx == IDX_LAST));
    w_idx_nxt   = r_idx;
    if (w_slot_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_nib = r_sh_digits[{r_idx, 2'b00} +: 4];
    w_hex = '0;
    case (w_nib)
      4'h0: w_hex = 7'h7E;
      4'h1: w_hex = 7'h30;
      4'h2: w_hex = 7'h6D;
      4'h3: w_hex = 7'h79;
      4'h4: w_hex = 7'h33;
      4'h5: w_hex = 7'h5B;
      4'h6: w_hex = 7'h5F;
      4'h7: w_hex = 7'h70;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h7B;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h1F;
      4'hC: w_hex = 7'h4E;
      4'hD: w_hex = 7'h3D;
      4'hE: w_hex = 7'h4F;
      4'hF: w_hex = 7'h47;
      default: w_hex = '0;
    endcase
    w_seg = w_hex;
    w_dp  = r_sh_dp[r_idx];
`ifdef SEVSEG_RAW_EN
    w_raw_byte = r_sh_raw[{r_idx, 3'b000} +: 8];
    if (r_sh_raw_sel[r_idx]) begin
      w_seg = w_raw_byte[7:1];
      w_dp  = w_raw_byte[0];
    end
`endif
  end

  always_comb begin
    w_lit = r_sh_en[r_idx] && (r_slot_cnt >= BLANK_FIRST) &&
            ((r_bright_cnt < r_sh_bright) || (r_sh_bright == '1));
    w_an  = '0;
    if (w_lit) begin
      w_an[r_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_started    <= 1'b0;
      r_slot_cnt   <= '0;
      r_idx        <= '0;
      r_bright_cnt <= '0;
      r_sh_digits  <= '0;
      r_sh_dp      <= '0;
      r_sh_en      <= '0;
      r_sh_bright  <= '0;
`ifdef SEVSEG_RAW_EN
      r_sh_raw     <= '0;
      r_sh_raw_sel <= '0;
`endif
    end else begin
      r_started    <= 1'b1;
      r_slot_cnt   <= w_slot_wrap ? '0 : r_slot_cnt + SLOT_W'(1);
      r_idx        <= w_idx_nxt;
      r_bright_cnt <= r_bright_cnt + BRIGHT_W'(1);
      if (w_load) begin
        r_sh_digits <= i_digits;
        r_sh_dp     <= i_dp;
        r_sh_en     <= i_en;
        r_sh_bright <= i_bright;
`ifdef SEVSEG_RAW_EN
        r_sh_raw     <= i_raw;
        r_sh_raw_sel <= i_raw_sel;
`endif
      end
    end
  end

  // Outputs lag the counter state by one clock, so anode switch and index change land together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_an    <= {NUM_DIGITS{POL}};
      r_seg   <= {7{POL}};
      r_dp    <= POL;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an ^ {NUM_DIGITS{POL}};
      r_seg   <= w_seg ^ {7{POL}};
      r_dp    <= w_dp ^ POL;
      r_frame <= w_load;
    end
  end

  assign o_an    = r_an;
  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl (8 digits, 100-cycle slots, 4-cycle blanking, active-low).
module tb_sevseg_scan_ctrl;
  localparam int ND    = 8;
  localparam int SD    = 100;
  localparam int BC    = 4;
  localparam int FRAME = ND * SD;
  localparam logic [6:0] HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_digits = '0;
  logic [7:0]  i_dp = '0;
  logic [7:0]  i_en = '0;
  logic [3:0]  i_bright = '0;
`ifdef SEVSEG_RAW_EN
  logic [63:0] i_raw = '0;
  logic [7:0]  i_raw_sel = '0;
`endif
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  exp_t sb[$];
  int   cq[$];

  sevseg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC),
    .BRIGHT_W  (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_digits (i_digits),
    .i_dp     (i_dp),
    .i_en     (i_en),
    .i_bright (i_bright),
`ifdef SEVSEG_RAW_EN
    .i_raw    (i_raw),
    .i_raw_sel(i_raw_sel),
`endif
    .o_an     (o_an),
    .o_seg    (o_seg),
    .o_dp     (o_dp),
    .o_frame  (o_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Returns at the negedge on which o_frame is first seen high, after at least one step.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * FRAME && !ok; n++) begin
      @(negedge clk);
      if (o_frame === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout no o_frame within %0d cycles, required a pulse", 2 * FRAME);
    end
  endtask

  task automatic test_reset();
    bit ok;
    i_digits = 32'h76543210; i_en = 8'hFF; i_dp = 8'h00; i_bright = 4'hF;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_an, o_seg, o_dp, o_frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold an=%h seg=%h dp=%b frame=%b required FF 7F 1 0", o_an, o_seg, o_dp, o_frame);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (o_frame !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_load frame=%b required 1", o_frame);
    end
    @(negedge clk);
    checks++;
    if (o_frame !== 1'b0) begin
      failures++;
      $display("FAIL frame_width frame=%b required 0", o_frame);
    end
    wait_frame(ok);
    repeat (350) @(negedge clk);
    checks++;
    if (o_an !== 8'hF7) begin
      failures++;
      $display("FAIL pre_reset_digit3 an=%h required F7", o_an);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({o_an, o_seg, o_dp, o_frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset an=%h seg=%h dp=%b frame=%b required FF 7F 1 0", o_an, o_seg, o_dp, o_frame);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (o_frame !== 1'b1) begin
      failures++;
      $display("FAIL rerelease_load frame=%b required 1", o_frame);
    end
  endtask

  task automatic test_scan();
    bit   ok;
    exp_t e;
    int   nfr;
    int   ss[4] = '{0, 3, 4, 99};
    i_digits = 32'h76543210; i_en = 8'hFF; i_dp = 8'h00; i_bright = 4'hF;
    for (int k = 0; k < ND; k++) begin
      foreach (ss[j]) begin
        e.cyc = SD * k + ss[j] + 1;
        e.an  = (ss[j] >= BC) ? ~(8'd1 << k) : 8'hFF;
        e.seg = ~HEX[k];
        e.dp  = 1'b1;
        sb.push_back(e);
      end
    end
    wait_frame(ok);
    nfr = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c < FRAME && o_frame === 1'b1) nfr++;
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({o_an, o_seg, o_dp} !== {e.an, e.seg, e.dp}) begin
          failures++;
          $display("FAIL scan c=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                   c, o_an, o_seg, o_dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (o_frame !== 1'b1 || nfr != 0) begin
      failures++;
      $display("FAIL frame_period frame@%0d=%b early_pulses=%0d required 1 and 0", FRAME, o_frame, nfr);
    end
    sb.delete();
  endtask

  task automatic test_coherency();
    bit   ok;
    exp_t e;
    i_digits = 32'h11111111; i_en = 8'hFF; i_dp = 8'h00; i_bright = 4'hF;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < ND; k++) begin
        e.cyc = f * FRAME + SD * k + 51;
        e.an  = ~(8'd1 << k);
        e.seg = ~HEX[f + 1];
        e.dp  = 1'b1;
        sb.push_back(e);
      end
    end
    wait_frame(ok);
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      if (c == 250) i_digits = 32'h22222222;
      if (c == FRAME) begin
        checks++;
        if (o_frame !== 1'b1) begin
          failures++;
          $display("FAIL coh_frame frame=%b required 1", o_frame);
        end
      end
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({o_an, o_seg, o_dp} !== {e.an, e.seg, e.dp}) begin
          failures++;
          $display("FAIL coherency c=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                   c, o_an, o_seg, o_dp, e.an, e.seg, e.dp);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_bright();
    bit ok;
    int lvl[3] = '{0, 4, 15};
    int lit, bad, exp_lit;
    i_digits = 32'h0; i_en = 8'hFF; i_dp = 8'h00;
    foreach (lvl[j]) begin
      i_bright = 4'(lvl[j]);
      cq.push_back((lvl[j] == 15) ? (SD - BC) : (SD - BC) * lvl[j] / 16);
      wait_frame(ok);
      lit = 0; bad = 0;
      for (int c = 1; c <= SD; c++) begin
        @(negedge clk);
        if (o_an === 8'hFE) begin
          if (c <= BC) bad++;
          else lit++;
        end else if (o_an !== 8'hFF) begin
          bad++;
        end
      end
      exp_lit = cq.pop_front();
      checks++;
      if (lit != exp_lit) begin
        failures++;
        $display("FAIL bright_%0d lit_cycles=%0d required %0d", lvl[j], lit, exp_lit);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL bright_%0d_blank bad_cycles=%0d required 0", lvl[j], bad);
      end
    end
  endtask

  task automatic test_en_dp();
    bit ok;
    int an_cnt[8];
    int dp0, dpx, nfr, ev;
    i_digits = 32'h76543210; i_en = 8'hA5; i_dp = 8'h01; i_bright = 4'hF;
    for (int k = 0; k < ND; k++) cq.push_back(i_en[k] ? (SD - BC) : 0);
    cq.push_back(SD);
    cq.push_back(0);
    wait_frame(ok);
    foreach (an_cnt[k]) an_cnt[k] = 0;
    dp0 = 0; dpx = 0; nfr = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) if (o_an[k] === 1'b0) an_cnt[k]++;
      if (o_dp === 1'b0) begin
        if (c <= SD) dp0++;
        else dpx++;
      end
      if (c < FRAME && o_frame === 1'b1) nfr++;
    end
    for (int k = 0; k < ND; k++) begin
      ev = cq.pop_front();
      checks++;
      if (an_cnt[k] != ev) begin
        failures++;
        $display("FAIL en_anode%0d active=%0d required %0d", k, an_cnt[k], ev);
      end
    end
    ev = cq.pop_front();
    checks++;
    if (dp0 != ev) begin
      failures++;
      $display("FAIL dp_digit0 active=%0d required %0d", dp0, ev);
    end
    ev = cq.pop_front();
    checks++;
    if (dpx != ev) begin
      failures++;
      $display("FAIL dp_others active=%0d required %0d", dpx, ev);
    end
    checks++;
    if (o_frame !== 1'b1 || nfr != 0) begin
      failures++;
      $display("FAIL en_frame_period frame=%b early_pulses=%0d required 1 and 0", o_frame, nfr);
    end
  endtask

`ifdef SEVSEG_RAW_EN
  task automatic test_raw();
    bit   ok;
    exp_t e;
    i_digits = 32'h76543210; i_en = 8'hFF; i_dp = 8'h00; i_bright = 4'hF;
    i_raw = {8'b1001_0011, {7{8'hFF}}}; i_raw_sel = 8'h80;
    for (int k = 0; k < ND; k++) begin
      e.cyc = SD * k + 51;
      e.an  = ~(8'd1 << k);
      e.seg = (k == 7) ? 7'h36 : ~HEX[k];
      e.dp  = (k == 7) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
    wait_frame(ok);
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({o_an, o_seg, o_dp} !== {e.an, e.seg, e.dp}) begin
          failures++;
          $display("FAIL raw c=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                   c, o_an, o_seg, o_dp, e.an, e.seg, e.dp);
        end
      end
    end
    sb.delete();
    i_raw_sel = 8'h00;
  endtask
`endif

  initial begin
    rstn = 1'b0;
    test_reset();
    test_scan();
    test_coherency();
    test_bright();
    test_en_dp();
`ifdef SEVSEG_RAW_EN
    test_raw();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
